// File: rtl/pa_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pa_dma                                                       |
// | Description : Shared types and constants for the byte-wide DMA engine:     |
// |               FSM state encoding, bus space encoding, default widths.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pa_dma;

   // Default widths; ADDR_W matches the CPU bus address width.
   localparam int DMA_ADDR_W = 22;
   localparam int DMA_CNT_W  = 16;

   // mem_io bus encoding.
   localparam logic MEM = 1'b1;
   localparam logic IO  = 1'b0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      READ    = 3'd2,
      WRITE   = 3'd3,
      RELEASE = 3'd4
   } dma_state_t;

endpackage : pa_dma
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_ctrl                                                     |
// | Description : Byte-wide DMA engine. Requests the CPU bus with dma_req,     |
// |               and once dma_ack is granted copies len bytes, one READ      |
// |               cycle followed by one WRITE cycle per byte, honouring       |
// |               wait_in. Grant is re-checked only at byte boundaries.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, arst_n          : clock, asynchronous active-low reset              |
// |   start                : start pulse, sampled in IDLE only                 |
// |   src_addr, dst_addr   : first source / destination address              |
// |   len                  : byte count (0 = immediate done, no bus request)   |
// |   src_mem, dst_mem     : per-side space select (1 = memory, 0 = I/O)      |
// |   src_fixed, dst_fixed : per-side hold address (FIFO / port)              |
// |   busy, done           : transfer in progress / one-cycle completion      |
// |   dma_req, dma_ack     : bus request / grant handshake with the CPU       |
// |   addr, data_in,       : bus address, read data, write data              |
// |   data_out                                                                 |
// |   rd, wr, mem_io       : bus strobes and space select                      |
// |   wait_in              : bus WAIT, stretches the current rd/wr cycle      |
// +----------------------------------------------------------------------------+
module dma_ctrl
   import pa_dma::*;
#(
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int CNT_W  = DMA_CNT_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  len,
   input  logic              src_mem,
   input  logic              dst_mem,
   input  logic              src_fixed,
   input  logic              dst_fixed,
   output logic              busy,
   output logic              done,
   output logic              dma_req,
   input  logic              dma_ack,
   output logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              rd,
   output logic              wr,
   output logic              mem_io,
   input  logic              wait_in
);

   dma_state_t        r_state;
   dma_state_t        w_state_next;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [CNT_W-1:0]  r_remain;
   logic              r_src_mem;
   logic              r_dst_mem;
   logic              r_src_fixed;
   logic              r_dst_fixed;
   logic [7:0]        r_data;
   logic              r_done;

   logic              w_last;

   // The byte now being written is the final one.
   assign w_last = (r_remain == CNT_W'(1));

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start && (len != '0)) begin
               w_state_next = REQ;
            end
         end
         REQ: begin
            if (dma_ack) begin
               w_state_next = READ;
            end
         end
         READ: begin
            if (!wait_in) begin
               w_state_next = WRITE;
            end
         end
         WRITE: begin
            // Grant is only re-examined here, between bytes; a dropped
            // dma_ack parks the engine in REQ with the request still raised.
            if (!wait_in) begin
               if (w_last) begin
                  w_state_next = RELEASE;
               end else if (dma_ack) begin
                  w_state_next = READ;
               end else begin
                  w_state_next = REQ;
               end
            end
         end
         RELEASE: begin
            if (!dma_ack) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- outputs
   // Decoded from registered state and registered datapath only, so no
   // input reaches an output combinationally.
   always_comb begin
      addr     = '0;
      data_out = '0;
      rd       = 1'b0;
      wr       = 1'b0;
      mem_io   = MEM;
      dma_req  = 1'b0;
      busy     = (r_state != IDLE);
      done     = r_done;
      case (r_state)
         REQ: begin
            dma_req = 1'b1;
         end
         READ: begin
            dma_req = 1'b1;
            addr    = r_src;
            rd      = 1'b1;
            mem_io  = r_src_mem ? MEM : IO;
         end
         WRITE: begin
            dma_req  = 1'b1;
            addr     = r_dst;
            wr       = 1'b1;
            data_out = r_data;
            mem_io   = r_dst_mem ? MEM : IO;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_remain    <= '0;
         r_src_mem   <= MEM;
         r_dst_mem   <= MEM;
         r_src_fixed <= 1'b0;
         r_dst_fixed <= 1'b0;
         r_data      <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_src       <= src_addr;
                  r_dst       <= dst_addr;
                  r_remain    <= len;
                  r_src_mem   <= src_mem;
                  r_dst_mem   <= dst_mem;
                  r_src_fixed <= src_fixed;
                  r_dst_fixed <= dst_fixed;
                  // Zero-length request completes without touching the bus.
                  r_done      <= (len == '0);
               end
            end
            READ: begin
               if (!wait_in) begin
                  r_data <= data_in;
               end
            end
            WRITE: begin
               if (!wait_in) begin
                  r_remain <= r_remain - CNT_W'(1);
                  // Addresses wrap modulo 2**ADDR_W by natural overflow.
                  if (!r_src_fixed) begin
                     r_src <= r_src + ADDR_W'(1);
                  end
                  if (!r_dst_fixed) begin
                     r_dst <= r_dst + ADDR_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (!dma_ack) begin
                  r_done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : dma_ctrl
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dma_ctrl                                                  |
// | Description : Self-checking bench for dma_ctrl. A CPU model grants the    |
// |               bus one cycle after dma_req; a bus model returns a byte     |
// |               derived from address/space. Expected bus cycles are queued  |
// |               when a transfer starts and matched against observed ones.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dma_ctrl;

   localparam int AW = 22;
   localparam int CW = 16;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic          mem_io;
      logic [7:0]    data;
   } txn_t;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [CW-1:0] len;
   logic          src_mem, dst_mem, src_fixed, dst_fixed;
   logic          busy, done, dma_req;
   logic          dma_ack = 1'b0;
   logic [AW-1:0] addr;
   logic [7:0]    data_in;
   logic [7:0]    data_out;
   logic          rd, wr, mem_io;
   logic          wait_in = 1'b0;

   int   n_checks = 0;
   int   n_fail   = 0;

   txn_t exp_q[$];
   txn_t obs_q[$];
   txn_t mon_t;
   int   rd_cycles, wr_cycles, done_cnt, req_at_done, both_strobe;

   bit   ack_allow = 1'b1;
   int   rd_waits  = 0;
   int   wcnt      = 0;

   always #5 clk = ~clk;

   dma_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .src_mem   (src_mem),
      .dst_mem   (dst_mem),
      .src_fixed (src_fixed),
      .dst_fixed (dst_fixed),
      .busy      (busy),
      .done      (done),
      .dma_req   (dma_req),
      .dma_ack   (dma_ack),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .rd        (rd),
      .wr        (wr),
      .mem_io    (mem_io),
      .wait_in   (wait_in)
   );

   // Bus content model: byte depends on address and space.
   function automatic logic [7:0] bus_byte(input logic [AW-1:0] a, input logic m);
      return a[7:0] ^ a[15:8] ^ (m ? 8'h5A : 8'hC3);
   endfunction

   assign data_in = bus_byte(addr, mem_io);

   // CPU model: grant follows request with one cycle of latency.
   always @(posedge clk) begin
      #1;
      dma_ack = dma_req && ack_allow;
   end

   // Slow-device model: stretch each read by rd_waits cycles.
   always @(posedge clk) begin
      #1;
      if (rd && (wcnt < rd_waits)) begin
         wait_in = 1'b1;
         wcnt++;
      end else begin
         wait_in = 1'b0;
         if (!rd) wcnt = 0;
      end
   end

   // Bus monitor: a strobe with wait_in low completes on the next edge.
   always @(negedge clk) begin
      if (arst_n) begin
         if (rd && !wait_in) begin
            mon_t.wr = 1'b0; mon_t.addr = addr; mon_t.mem_io = mem_io; mon_t.data = data_in;
            obs_q.push_back(mon_t);
         end
         if (wr && !wait_in) begin
            mon_t.wr = 1'b1; mon_t.addr = addr; mon_t.mem_io = mem_io; mon_t.data = data_out;
            obs_q.push_back(mon_t);
         end
         if (rd) rd_cycles++;
         if (wr) wr_cycles++;
         if (done) done_cnt++;
         if (done && dma_req) req_at_done++;
         if (rd && wr) both_strobe++;
      end
   end

   task automatic clear_counts();
      rd_cycles = 0; wr_cycles = 0; done_cnt = 0; req_at_done = 0; both_strobe = 0;
      obs_q.delete();
      exp_q.delete();
   endtask

   // Queue the expected read/write bus cycles of one transfer.
   task automatic push_expected(input logic [AW-1:0] s0, input logic [AW-1:0] d0,
                                input int n, input logic sm, input logic dm,
                                input logic sf, input logic df);
      logic [AW-1:0] s, d;
      txn_t t;
      s = s0; d = d0;
      for (int i = 0; i < n; i++) begin
         t.wr = 1'b0; t.addr = s; t.mem_io = sm; t.data = bus_byte(s, sm);
         exp_q.push_back(t);
         t.wr = 1'b1; t.addr = d; t.mem_io = dm;
         exp_q.push_back(t);
         if (!sf) s = s + 1'b1;
         if (!df) d = d + 1'b1;
      end
   endtask

   // Present a transfer request; start is high across exactly one posedge.
   task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                             input logic sm, input logic dm, input logic sf, input logic df);
      @(negedge clk);
      src_addr = s; dst_addr = d; len = CW'(n);
      src_mem = sm; dst_mem = dm; src_fixed = sf; dst_fixed = df;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      bit ok;
      // Power-on reset values.
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, dma_req, rd, wr, mem_io, addr, data_out} !== {6'b000001, {AW{1'b0}}, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_por: got %b_%h_%h required 000001_000000_00",
                  {busy, done, dma_req, rd, wr, mem_io}, addr, data_out);
      end
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      clear_counts();
      // Abort in the middle of a WRITE cycle.
      start_xfer(22'h000700, 22'h000800, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (wr) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_reach_write: wr never seen, required wr=1 within 40 cycles");
      end
      #2;
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, dma_req, rd, wr, mem_io, addr} !== {6'b000001, {AW{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_abort: got %b addr %h required 000001 addr 000000",
                  {busy, done, dma_req, rd, wr, mem_io}, addr);
      end
      done_cnt = 0;
      repeat (3) @(negedge clk);
      #2;
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_cnt !== 0 || busy !== 1'b0 || dma_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: got done_cnt=%0d busy=%b req=%b required 0 0 0",
                  done_cnt, busy, dma_req);
      end
      clear_counts();
   endtask

   task automatic test_mem_copy();
      bit   ok;
      txn_t e, o;
      clear_counts();
      push_expected(22'h000100, 22'h000200, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      start_xfer(22'h000100, 22'h000200, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (busy !== 1'b1 || dma_req !== 1'b1) begin
         n_fail++;
         $display("FAIL copy_start_latency: got busy=%b req=%b required 1 1", busy, dma_req);
      end
      wait_done(60, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL copy_done_timeout: no done in 60 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL copy_txn: got none required %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL copy_txn: got %h required %h", o, e); end
         end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL copy_extra: got %0d extra cycles required 0", obs_q.size()); end
      n_checks++;
      if (rd_cycles + wr_cycles != 8 || both_strobe != 0) begin
         n_fail++; $display("FAIL copy_strobes: got %0d (both=%0d) required 8 (both=0)", rd_cycles + wr_cycles, both_strobe);
      end
      n_checks++;
      if (done_cnt != 1 || req_at_done != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL copy_done: got done_cnt=%0d req_at_done=%0d busy=%b required 1 0 0", done_cnt, req_at_done, busy);
      end
   endtask

   task automatic test_io_fixed();
      bit   ok;
      txn_t e, o;
      clear_counts();
      rd_waits = 2;
      push_expected(22'h000010, 22'h001000, 3, 1'b0, 1'b1, 1'b1, 1'b0);
      start_xfer(22'h000010, 22'h001000, 3, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_done(80, ok);
      rd_waits = 0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL io_done_timeout: no done in 80 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL io_txn: got none required %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL io_txn: got %h required %h", o, e); end
         end
      end
      n_checks++;
      if (rd_cycles != 9 || wr_cycles != 3) begin
         n_fail++; $display("FAIL io_cycles: got rd=%0d wr=%0d required rd=9 wr=3", rd_cycles, wr_cycles);
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL io_done_count: got %0d required 1", done_cnt); end
   endtask

   task automatic test_len0_and_busy();
      bit   ok;
      txn_t e, o;
      clear_counts();
      start_xfer(22'h000050, 22'h000060, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || dma_req !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL len0_done: got done=%b req=%b busy=%b required 1 0 0", done, dma_req, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || dma_req !== 1'b0) begin
         n_fail++; $display("FAIL len0_single: got done=%b req=%b required 0 0", done, dma_req);
      end
      clear_counts();
      push_expected(22'h000020, 22'h000030, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      start_xfer(22'h000020, 22'h000030, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      start_xfer(22'h000999, 22'h000AAA, 5, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_done(60, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL busy_done_timeout: no done in 60 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL busy_txn: got none required %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL busy_txn: got %h required %h", o, e); end
         end
      end
      n_checks++;
      if (obs_q.size() != 0 || done_cnt != 1) begin
         n_fail++; $display("FAIL busy_ignored: got extra=%0d done_cnt=%0d required 0 1", obs_q.size(), done_cnt);
      end
   endtask

   task automatic test_pause_wrap();
      bit   ok;
      txn_t e, o;
      clear_counts();
      push_expected(22'h000300, 22'h000400, 3, 1'b1, 1'b1, 1'b0, 1'b0);
      start_xfer(22'h000300, 22'h000400, 3, 1'b1, 1'b1, 1'b0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pause_first_read: rd not seen in 20 cycles"); end
      ack_allow = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (dma_req !== 1'b1 || rd !== 1'b0 || wr !== 1'b0 || busy !== 1'b1 || obs_q.size() != 2) begin
         n_fail++; $display("FAIL pause_hold: got req=%b rd=%b wr=%b busy=%b cycles=%0d required 1 0 0 1 2",
                            dma_req, rd, wr, busy, obs_q.size());
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (dma_req !== 1'b1 || rd !== 1'b0 || obs_q.size() != 2) begin
         n_fail++; $display("FAIL pause_still: got req=%b rd=%b cycles=%0d required 1 0 2", dma_req, rd, obs_q.size());
      end
      ack_allow = 1'b1;
      wait_done(60, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pause_done_timeout: no done in 60 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL pause_txn: got none required %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL pause_txn: got %h required %h", o, e); end
         end
      end
      // Source address wrap at the top of the address space.
      clear_counts();
      push_expected(22'h3FFFFF, 22'h000600, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      start_xfer(22'h3FFFFF, 22'h000600, 2, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_done(60, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout: no done in 60 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL wrap_txn: got none required %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL wrap_txn: got %h required %h", o, e); end
         end
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d required 1", done_cnt); end
   endtask

   initial begin
      start = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      src_mem = 1'b1; dst_mem = 1'b1; src_fixed = 1'b0; dst_fixed = 1'b0;
      clear_counts();
      test_reset();
      test_mem_copy();
      test_io_fixed();
      test_len0_and_busy();
      test_pause_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by 200000 ns");
      $fatal(1, "watchdog");
   end

endmodule : tb_dma_ctrl
`default_nettype wire

// File: doc/dma_ctrl.md
# dma_ctrl

Byte-wide DMA engine forming the requesting end of the CPU's bus-grant handshake (dma_req/dma_ack). Once `cpu_top` grants the bus, the block drives the same bus signals the CPU normally owns (addr, rd, wr, mem_io, data) to copy a block of bytes between memory and/or I/O space. It honours the bus WAIT line, then hands the bus back to the CPU.

## Interface
- ADDR_W, 22: bus address width; matches `cpu_top` addr.
- CNT_W, 16: transfer length counter width.

- clk  in  1  system clock.
- arst_n  in  1  asynchronous reset, active low.
- start  in  1  one-cycle start pulse; sampled only in IDLE.
- src_addr  in  ADDR_W  first source address; latched on accepted start.
- dst_addr  in  ADDR_W  first destination address; latched on accepted start.
- len  in  CNT_W  byte count; 0 = no transfer.
- src_mem, dst_mem  in  1  space select per side: 1 = memory, 0 = I/O.
- src_fixed, dst_fixed  in  1  1 = address does not increment (FIFO/port).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- dma_req  out  1  bus request to CPU.
- dma_ack  in  1  bus grant from CPU.
- addr  out  ADDR_W  bus address.
- data_in  in  8  read data from bus.
- data_out  out  8  write data to bus.
- rd, wr  out  1  bus strobes, active high, never both high.
- mem_io  out  1  1 = memory cycle, 0 = I/O cycle.
- wait_in  in  1  bus WAIT; 1 stretches the current rd/wr cycle.

## Operation
- States: IDLE, REQ, READ, WRITE, RELEASE.
- IDLE: start=1 latches src/dst/len/space/fixed. len≠0 → REQ; len=0 → done pulse next cycle, stay IDLE, dma_req never raised.
- start while busy: ignored, no effect on the running transfer.
- REQ: dma_req=1; dma_ack=1 → READ.
- READ: addr=src, rd=1, mem_io=src_mem. Held while wait_in=1; on the cycle with wait_in=0, data_in is latched → WRITE.
- WRITE: addr=dst, wr=1, data_out=latched byte, mem_io=dst_mem. Held while wait_in=1; on exit: remaining-1, src+1 unless src_fixed, dst+1 unless dst_fixed.
  - Remaining becomes 0 → RELEASE.
  - Otherwise dma_ack=1 → READ; dma_ack=0 → REQ (pause; dma_req stays high and resumes at the next byte).
- dma_ack dropped mid READ/WRITE: current byte completes; check is made only at byte boundaries.
- RELEASE: dma_req=0, bus outputs idle; dma_ack=0 → IDLE with done=1 for that one cycle, busy=0.
- Address arithmetic: ADDR_W-bit modulo. 3FFFFF+1 → 000000, no error.
- Bus outputs outside READ/WRITE: addr=0, data_out=0, rd=wr=0, mem_io=1.

## Timing
- Reset (arst_n=0, asynchronous): state=IDLE. busy, done, dma_req, rd, wr all 0. addr=0, data_out=0, mem_io=1. Internal counters cleared.
- Reset mid-transfer aborts immediately. No done pulse; the bus is released in the same instant.
- All outputs are registered, or decoded from registered state only. No combinational path from any input to any output.
- start at edge N → busy=1 and dma_req=1 after edge N+1.
- dma_ack seen high at edge M → rd=1 after edge M+1.
- Minimum 2 cycles per byte with wait_in=0. Each wait_in=1 cycle adds one cycle.
- A len=k transfer with zero waits and continuous grant occupies 2k cycles of rd/wr.
- done asserts on the edge after dma_ack is seen low in RELEASE.

## Structure
- Package pa_dma holds:
  - the state enum typedef (IDLE, REQ, READ, WRITE, RELEASE);
  - the mem_io encoding constants (MEM=1, IO=0);
  - the default ADDR_W/CNT_W.
- Single module; no sub-module. Counter and address incrementers stay inline.

## Test plan
- Reset: arst_n low mid-WRITE → rd=wr=dma_req=busy=0 immediately; addr=0, mem_io=1; no done pulse.
- Mem→mem copy: src=000100, dst=000200, len=4, ack immediate → reads 100..103 and writes 200..203 alternate, bytes match; 8 strobe cycles; done once; dma_req low before done.
- I/O→mem with fixed source: src=000010 (I/O, fixed), dst=001000, len=3, wait_in=1 for 2 cycles on each read → addr stays 10 with mem_io=0 on reads; dst advances 1000..1002; each READ lasts 3 cycles.
- len=0, and start while busy: len=0 → done next cycle, dma_req stays 0. Second start during a len=2 run → ignored, exactly 2 bytes moved.
- Grant pause and wrap: dma_ack drops during byte 1 of len=3 → byte 1 completes; FSM holds REQ with dma_req=1; resumes at byte 2 when ack returns. Separately, src=3FFFFF, len=2 → second read at 000000.
